snake_game_ctrl: RTL
====================

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter TICK_INIT, default 2500000: clock cycles per snake move at game start.
REQ-002 Parameter TICK_MIN, default 625000: minimum cycles per move (speed ceiling).
REQ-003 Parameter TICK_STEP, default 125000: period reduction per food eaten.
REQ-004 CLK  input  1  system clock (25 MHz game clock); one clock; reset is synchronous and active-low.
REQ-005 RESET_N  input  1  synchronous active-low reset, sampled on rising CLK edge.
REQ-006 keycode  input  8  PS/2 set-2 scan byte from keyboard controller.
REQ-007 key_strobe  input  1  one-cycle pulse: keycode holds a newly received byte.
REQ-008 hit_wall  input  1  level: snake head on border this move.
REQ-009 hit_self  input  1  level: snake head on body this move.
REQ-010 ate_food  input  1  one-cycle pulse: head reached food.
REQ-011 direction  output  2  applied heading: 00 up, 01 right, 10 down, 11 left.
REQ-012 move  output  1  one-cycle pulse: advance snake one cell.
REQ-013 game_state  output  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
REQ-014 score  output  8  foods eaten this game.

Function
REQ-015 Key decode SHALL act only on key_strobe cycles: 0x1D=W up, 0x23=D right, 0x1B=S down, 0x1C=A left, 0x29=space; all other bytes ignored.
REQ-016 Byte 0xF0 SHALL set a break flag; the next strobed byte SHALL be discarded and clear the flag (key releases never act).
REQ-017 Byte 0xE0 SHALL be ignored without affecting the break flag.
REQ-018 Direction keys SHALL be accepted only in PLAY; accepted key writes pending_dir unless it equals direction XOR 2'b10 (reversal), which is ignored.
REQ-019 Reversal check SHALL compare against applied direction, not pending_dir; last accepted key before a move wins.
REQ-020 On each move pulse, direction SHALL take pending_dir in the same cycle the pulse is asserted (so direction changes at most once per move).
REQ-021 State machine: IDLE --space--> PLAY; PLAY --space--> PAUSE; PAUSE --space--> PLAY; PLAY --(hit_wall|hit_self)--> OVER; OVER --space--> IDLE.
REQ-022 IDLE->PLAY SHALL clear score, tick counter and set direction = pending_dir = 01, period = TICK_INIT.
REQ-023 Tick counter SHALL increment only in PLAY; move SHALL pulse in the cycle counter equals period-1, counter then returns to 0; first move exactly period cycles after entering PLAY.
REQ-024 PAUSE SHALL freeze tick counter, direction, pending_dir, score, period; resume continues from frozen count.
REQ-025 Collision inputs SHALL be sampled only in PLAY; move SHALL NOT pulse in the cycle the OVER transition is taken, nor at any time outside PLAY.
REQ-026 ate_food in PLAY SHALL increment score, saturating at 255, and reduce period by TICK_STEP, floored at TICK_MIN; new period applies to the current count.
REQ-027 ate_food and collision in the same cycle: collision wins, score and period unchanged.
REQ-028 Space and collision in the same PLAY cycle: collision wins (-> OVER).
REQ-029 score and direction SHALL hold their final values in OVER and IDLE until the next game start.
REQ-030 Tick counter and period SHALL be 22 bits; unsigned arithmetic, floor check done before subtraction (no underflow).

Reset
REQ-031 While RESET_N low at a CLK edge: game_state=IDLE, direction=01, pending_dir=01, move=0, score=0, period=TICK_INIT, counter=0, break flag=0.
REQ-032 Reset asserted mid-game (any state) SHALL override all inputs in that cycle and return to REQ-031 values on the next edge.

Verification (TICK_INIT=8, TICK_MIN=4, TICK_STEP=2)
REQ-033 Reset, strobe 0x29 -> game_state=01, move pulses 8 cycles after entry, then every 8 cycles, direction=01.
REQ-034 In PLAY strobe 0x1C (left while right) -> ignored, direction stays 01; strobe 0x1D then 0x1C before next move -> at move direction=11? no: 0x1C reversal vs applied 01 ignored, direction=00 at next move.
REQ-035 Strobe 0xF0,0x1B -> no direction change; then 0x1B -> direction=10 at next move.
REQ-036 Three ate_food pulses -> score=3, move interval 8->6->4->4.
REQ-037 Space mid-count (counter=3) -> PAUSE, no move for 20 cycles; space -> PLAY, first move after 5 more cycles.
REQ-038 hit_self with ate_food same cycle -> game_state=11, score unchanged, no further move; space -> IDLE; space -> PLAY with score=0, direction=01.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game controller: PS/2 key decode, game FSM, move tick, score and speed
//
// Ports:
//   CLK         game clock
//   RESET_N     synchronous active-low reset
//   keycode     PS/2 set-2 scan byte, qualified by key_strobe
//   key_strobe  one-cycle pulse, keycode holds a new byte
//   hit_wall    level, snake head on border this move
//   hit_self    level, snake head on body this move
//   ate_food    one-cycle pulse, head reached food
//   direction   applied heading (00 up, 01 right, 10 down, 11 left)
//   move        one-cycle pulse, advance snake one cell
//   game_state  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   score       foods eaten this game, saturating at 255
module snake_game_ctrl #(
    parameter int TICK_INIT = 2500000,
    parameter int TICK_MIN  = 625000,
    parameter int TICK_STEP = 125000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] keycode,
    input  logic       key_strobe,
    input  logic       hit_wall,
    input  logic       hit_self,
    input  logic       ate_food,
    output logic [1:0] direction,
    output logic       move,
    output logic [1:0] game_state,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam logic [21:0] P_INIT = 22'(TICK_INIT);
    localparam logic [21:0] P_MIN  = 22'(TICK_MIN);
    localparam logic [21:0] P_STEP = 22'(TICK_STEP);
    // One extra bit so the floor threshold itself cannot overflow.
    localparam logic [22:0] P_FLOOR_SUM = {1'b0, P_MIN} + {1'b0, P_STEP};

    localparam logic [7:0] KC_UP    = 8'h1D;
    localparam logic [7:0] KC_RIGHT = 8'h23;
    localparam logic [7:0] KC_DOWN  = 8'h1B;
    localparam logic [7:0] KC_LEFT  = 8'h1C;
    localparam logic [7:0] KC_SPACE = 8'h29;
    localparam logic [7:0] KC_BREAK = 8'hF0;
    localparam logic [7:0] KC_EXT   = 8'hE0;

    state_e      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_q, pend_d;
    logic [7:0]  score_q, score_d;
    logic [21:0] period_q, period_d;
    logic [21:0] cnt_q, cnt_d;
    logic        brk_q, brk_d;
    logic        move_q, move_d;

    logic        key_space;
    logic        key_dir_vld;
    logic [1:0]  key_dir;
    logic        collision;

    // Key decode. The extended prefix is transparent so that E0 F0 xx
    // releases still discard xx.
    always_comb begin
        brk_d       = brk_q;
        key_space   = 1'b0;
        key_dir_vld = 1'b0;
        key_dir     = 2'b00;
        if (key_strobe && keycode != KC_EXT) begin
            if (brk_q) begin
                brk_d = 1'b0;
            end else if (keycode == KC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                case (keycode)
                    KC_UP:    begin key_dir_vld = 1'b1; key_dir = 2'b00; end
                    KC_RIGHT: begin key_dir_vld = 1'b1; key_dir = 2'b01; end
                    KC_DOWN:  begin key_dir_vld = 1'b1; key_dir = 2'b10; end
                    KC_LEFT:  begin key_dir_vld = 1'b1; key_dir = 2'b11; end
                    KC_SPACE: key_space = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign collision = hit_wall | hit_self;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        score_d  = score_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        move_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_space) begin
                    state_d  = ST_PLAY;
                    score_d  = 8'd0;
                    cnt_d    = 22'd0;
                    dir_d    = 2'b01;
                    pend_d   = 2'b01;
                    period_d = P_INIT;
                end
            end
            ST_PLAY: begin
                // Collision outranks both pause and food in the same cycle.
                if (collision) begin
                    state_d = ST_OVER;
                end else if (key_space) begin
                    state_d = ST_PAUSE;
                end else begin
                    // Reversal is judged against the applied heading, so two
                    // quick turns cannot fold the snake back onto itself.
                    if (key_dir_vld && key_dir != (dir_q ^ 2'b10)) begin
                        pend_d = key_dir;
                    end
                    if (ate_food) begin
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                        if ({1'b0, period_q} >= P_FLOOR_SUM) begin
                            period_d = period_q - P_STEP;
                        end else begin
                            period_d = P_MIN;
                        end
                    end
                    // >= rather than == so a period shrunk below the running
                    // count still fires instead of wrapping the counter.
                    if (cnt_q >= period_q - 22'd1) begin
                        cnt_d  = 22'd0;
                        move_d = 1'b1;
                        dir_d  = pend_q;
                    end else begin
                        cnt_d = cnt_q + 22'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (key_space) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (key_space) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            dir_q    <= 2'b01;
            pend_q   <= 2'b01;
            score_q  <= 8'd0;
            period_q <= P_INIT;
            cnt_q    <= 22'd0;
            brk_q    <= 1'b0;
            move_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            score_q  <= score_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            brk_q    <= brk_d;
            move_q   <= move_d;
        end
    end

    // move is registered together with the heading update, so the cycle
    // move is high already shows the new direction.
    assign direction  = dir_q;
    assign move       = move_q;
    assign game_state = state_q;
    assign score      = score_q;

endmodule
